// File: rtl/gas_engine_safety_ctrl.sv
// Supervisory FSM that sequences engine, fan and gas valve from the sticky
// methane/CO/CO2 detector flags: warn, escalate to shutdown, timed purge, restart.
module gas_engine_safety_ctrl #(
  parameter int ESCALATE_CYCLES = 8,
  parameter int PURGE_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       methane_det,
  input  logic       co_det,
  input  logic       co2_det,
  input  logic       ack,
  output logic       engine_on,
  output logic       fan_on,
  output logic       valve_close,
  output logic [1:0] alarm,
  output logic       det_clear,
  output logic [1:0] gas_code
);

  localparam int CNT_MAX = (ESCALATE_CYCLES > PURGE_CYCLES) ? ESCALATE_CYCLES : PURGE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(2);
  localparam logic [CNT_W-1:0] ESC_LAST   = CNT_W'(ESCALATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PURGE_LAST = CNT_W'(PURGE_CYCLES - 1);

  localparam logic [1:0] GAS_NONE    = 2'd0;
  localparam logic [1:0] GAS_METHANE = 2'd1;
  localparam logic [1:0] GAS_CO      = 2'd2;
  localparam logic [1:0] GAS_CO2     = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WARN     = 2'd1,
    ST_SHUTDOWN = 2'd2,
    ST_PURGE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             det_clear_q, det_clear_d;
  logic [1:0]       gas_code_q, gas_code_d;
  logic             engine_on_q, engine_on_d;
  logic             fan_on_q, fan_on_d;
  logic             valve_close_q, valve_close_d;
  logic [1:0]       alarm_q, alarm_d;

  // Next-state, counter, clear pulse and latched cause
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    det_clear_d = 1'b0;
    gas_code_d  = gas_code_q;
    case (state_q)
      ST_RUN: begin
        if (methane_det) begin
          state_d    = ST_SHUTDOWN;
          cnt_d      = CNT_ZERO;
          gas_code_d = GAS_METHANE;
        end else if (co_det) begin
          state_d    = ST_WARN;
          cnt_d      = CNT_ZERO;
          gas_code_d = GAS_CO;
        end else if (co2_det) begin
          state_d    = ST_WARN;
          cnt_d      = CNT_ZERO;
          gas_code_d = GAS_CO2;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WARN: begin
        if (methane_det) begin
          state_d    = ST_SHUTDOWN;
          cnt_d      = CNT_ZERO;
          gas_code_d = GAS_METHANE;
        end else if (ack) begin
          state_d     = ST_PURGE;
          cnt_d       = CNT_ZERO;
          det_clear_d = 1'b1;
        end else if (cnt_q == ESC_LAST) begin
          state_d = ST_SHUTDOWN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SHUTDOWN: begin
        if (ack) begin
          state_d     = ST_PURGE;
          cnt_d       = CNT_ZERO;
          det_clear_d = 1'b1;
        end else begin
          state_d = ST_SHUTDOWN;
        end
      end
      ST_PURGE: begin
        // Detector flags are stale for two cycles while the clear propagates
        if (cnt_q < SETTLE_CNT) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (methane_det) begin
          state_d    = ST_SHUTDOWN;
          cnt_d      = CNT_ZERO;
          gas_code_d = GAS_METHANE;
        end else if (co_det || co2_det) begin
          cnt_d       = CNT_ZERO;
          det_clear_d = 1'b1;
          gas_code_d  = co_det ? GAS_CO : GAS_CO2;
        end else if (cnt_q == PURGE_LAST) begin
          state_d    = ST_RUN;
          cnt_d      = CNT_ZERO;
          gas_code_d = GAS_NONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d     = ST_PURGE;
        cnt_d       = CNT_ZERO;
        det_clear_d = 1'b1;
        gas_code_d  = GAS_NONE;
      end
    endcase
  end

  // Actuator decode from the next state so outputs register alongside it
  always_comb begin
    engine_on_d   = 1'b0;
    fan_on_d      = 1'b1;
    valve_close_d = 1'b1;
    alarm_d       = 2'd3;
    case (state_d)
      ST_RUN: begin
        engine_on_d   = 1'b1;
        fan_on_d      = 1'b0;
        valve_close_d = 1'b0;
        alarm_d       = 2'd0;
      end
      ST_WARN: begin
        engine_on_d   = 1'b1;
        fan_on_d      = 1'b1;
        valve_close_d = 1'b0;
        alarm_d       = 2'd1;
      end
      ST_SHUTDOWN: begin
        engine_on_d   = 1'b0;
        fan_on_d      = 1'b1;
        valve_close_d = 1'b1;
        alarm_d       = 2'd2;
      end
      ST_PURGE: begin
        engine_on_d   = 1'b0;
        fan_on_d      = 1'b1;
        valve_close_d = 1'b1;
        alarm_d       = 2'd3;
      end
      default: begin
        engine_on_d   = 1'b0;
        fan_on_d      = 1'b1;
        valve_close_d = 1'b1;
        alarm_d       = 2'd3;
      end
    endcase
  end

  // State and output registers; reset lands in a full purge
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= ST_PURGE;
      cnt_q         <= CNT_ZERO;
      det_clear_q   <= 1'b1;
      gas_code_q    <= GAS_NONE;
      engine_on_q   <= 1'b0;
      fan_on_q      <= 1'b1;
      valve_close_q <= 1'b1;
      alarm_q       <= 2'd3;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      det_clear_q   <= det_clear_d;
      gas_code_q    <= gas_code_d;
      engine_on_q   <= engine_on_d;
      fan_on_q      <= fan_on_d;
      valve_close_q <= valve_close_d;
      alarm_q       <= alarm_d;
    end
  end

  assign engine_on   = engine_on_q;
  assign fan_on      = fan_on_q;
  assign valve_close = valve_close_q;
  assign alarm       = alarm_q;
  assign det_clear   = det_clear_q;
  assign gas_code    = gas_code_q;

endmodule

// File: tb/tb_gas_engine_safety_ctrl.sv
// Directed bench for gas_engine_safety_ctrl: behavioural model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_gas_engine_safety_ctrl;

  localparam int ESC   = 8;
  localparam int PURGE = 16;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       methane_det = 1'b0;
  logic       co_det = 1'b0;
  logic       co2_det = 1'b0;
  logic       ack = 1'b0;
  logic       engine_on, fan_on, valve_close, det_clear;
  logic [1:0] alarm, gas_code;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  gas_engine_safety_ctrl #(
    .ESCALATE_CYCLES(ESC),
    .PURGE_CYCLES(PURGE)
  ) dut (
    .clk(clk),
    .arst(arst),
    .methane_det(methane_det),
    .co_det(co_det),
    .co2_det(co2_det),
    .ack(ack),
    .engine_on(engine_on),
    .fan_on(fan_on),
    .valve_close(valve_close),
    .alarm(alarm),
    .det_clear(det_clear),
    .gas_code(gas_code)
  );

  // Model: mode, cycles spent in the current mode/purge epoch, cause, clear pulse
  localparam int M_RUN = 0, M_WARN = 1, M_SHUT = 2, M_PURGE = 3;
  int m_mode = M_PURGE;
  int m_age  = 0;
  int m_gas  = 0;
  bit m_clr  = 1'b1;

  task automatic m_go(input int mode, input int gas);
    m_mode = mode;
    m_gas  = gas;
    m_age  = 0;
  endtask

  task automatic m_start_purge(input int gas);
    m_go(M_PURGE, gas);
    m_clr = 1'b1;
  endtask

  task automatic m_step();
    m_clr = 1'b0;
    if (m_mode == M_RUN) begin
      if (methane_det) m_go(M_SHUT, 1);
      else if (co_det) m_go(M_WARN, 2);
      else if (co2_det) m_go(M_WARN, 3);
    end else if (m_mode == M_WARN) begin
      if (methane_det) m_go(M_SHUT, 1);
      else if (ack) m_start_purge(m_gas);
      else begin
        m_age++;
        if (m_age == ESC) m_go(M_SHUT, m_gas);
      end
    end else if (m_mode == M_SHUT) begin
      if (ack) m_start_purge(m_gas);
    end else begin
      if (m_age >= 2 && methane_det) m_go(M_SHUT, 1);
      else if (m_age >= 2 && (co_det || co2_det)) m_start_purge(co_det ? 2 : 3);
      else begin
        m_age++;
        if (m_age == PURGE) m_go(M_RUN, 0);
      end
    end
  endtask

  function automatic logic [7:0] m_expect();
    logic e, f, v;
    e = (m_mode == M_RUN) || (m_mode == M_WARN);
    f = (m_mode != M_RUN);
    v = (m_mode == M_SHUT) || (m_mode == M_PURGE);
    return {e, f, v, 2'(m_mode), m_clr, 2'(m_gas)};
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge arst);
      if (arst) begin
        m_mode = M_PURGE;
        m_age  = 0;
        m_gas  = 0;
        m_clr  = 1'b1;
      end else begin
        m_step();
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!arst) begin
        n_total++;
        if ({engine_on, fan_on, valve_close, alarm, det_clear, gas_code} == m_expect())
          n_pass++;
        else
          $display("FAIL model_cycle t=%0t: got %b required %b", $time,
                   {engine_on, fan_on, valve_close, alarm, det_clear, gas_code}, m_expect());
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_engine"}, engine_on, 0);
    chk({tag, "_fan"}, fan_on, 1);
    chk({tag, "_valve"}, valve_close, 1);
    chk({tag, "_alarm"}, alarm, 3);
    chk({tag, "_clr"}, det_clear, 1);
    chk({tag, "_gas"}, gas_code, 0);
  endtask

  // Called on the first cycle of a purge epoch; runs it through to RUN
  task automatic purge_to_run(input string tag, input int gas_exp);
    chk({tag, "_clr_first"}, det_clear, 1);
    chk({tag, "_alarm_first"}, alarm, 3);
    chk({tag, "_gas_first"}, gas_code, gas_exp);
    step(1);
    chk({tag, "_clr_second"}, det_clear, 0);
    step(14);
    chk({tag, "_alarm_last"}, alarm, 3);
    chk({tag, "_gas_last"}, gas_code, gas_exp);
    step(1);
    chk({tag, "_alarm_run"}, alarm, 0);
    chk({tag, "_engine_run"}, engine_on, 1);
    chk({tag, "_gas_run"}, gas_code, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    // 1: reset and initial purge
    step(2);
    chk_reset_vals("t1_reset");
    @(posedge clk);
    #1 arst = 1'b0;
    step(1);
    purge_to_run("t1", 0);

    // 2: CO warning escalates to shutdown, which then waits for ack
    co_det = 1'b1; step(1); co_det = 1'b0;
    chk("t2_warn_alarm", alarm, 1);
    chk("t2_warn_fan", fan_on, 1);
    chk("t2_warn_gas", gas_code, 2);
    step(7);
    chk("t2_warn_last", alarm, 1);
    step(1);
    chk("t2_shut_alarm", alarm, 2);
    chk("t2_shut_engine", engine_on, 0);
    chk("t2_shut_valve", valve_close, 1);
    chk("t2_shut_gas", gas_code, 2);
    step(3);
    chk("t2_shut_hold", alarm, 2);
    ack = 1'b1; step(1); ack = 1'b0;
    purge_to_run("t2", 2);

    // 3: CO2 warning acknowledged on WARN cycle 3
    co2_det = 1'b1; step(1); co2_det = 1'b0;
    chk("t3_warn_gas", gas_code, 3);
    step(2);
    ack = 1'b1; step(1); ack = 1'b0;
    purge_to_run("t3", 3);

    // 4: methane beats ack in WARN
    co_det = 1'b1; step(1); co_det = 1'b0;
    methane_det = 1'b1; ack = 1'b1; step(1); methane_det = 1'b0; ack = 1'b0;
    chk("t4_shut_alarm", alarm, 2);
    chk("t4_shut_gas", gas_code, 1);
    ack = 1'b1; step(1); ack = 1'b0;
    purge_to_run("t4", 1);

    // 5: CO during purge ignored at cnt=1, restarts purge at cnt=9
    co_det = 1'b1; step(1); co_det = 1'b0;
    ack = 1'b1; step(1); ack = 1'b0;
    step(1);
    co_det = 1'b1; step(1); co_det = 1'b0;
    chk("t5_ignored_alarm", alarm, 3);
    chk("t5_ignored_clr", det_clear, 0);
    step(7);
    co_det = 1'b1; step(1); co_det = 1'b0;
    purge_to_run("t5", 2);

    // 5b: CO restart changes cause, then methane in purge forces shutdown
    co2_det = 1'b1; step(1); co2_det = 1'b0;
    ack = 1'b1; step(1); ack = 1'b0;
    chk("t5b_purge_gas", gas_code, 3);
    step(3);
    co_det = 1'b1; step(1); co_det = 1'b0;
    chk("t5b_restart_clr", det_clear, 1);
    chk("t5b_restart_gas", gas_code, 2);
    step(4);
    methane_det = 1'b1; step(1); methane_det = 1'b0;
    chk("t5b_shut_alarm", alarm, 2);
    chk("t5b_shut_gas", gas_code, 1);

    // 6: asynchronous reset from SHUTDOWN
    step(2);
    arst = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    @(posedge clk);
    #1 arst = 1'b0;
    step(1);
    purge_to_run("t6", 0);

    // 7: all inputs at once in RUN -> methane wins
    methane_det = 1'b1; co_det = 1'b1; co2_det = 1'b1; ack = 1'b1;
    step(1);
    methane_det = 1'b0; co_det = 1'b0; co2_det = 1'b0; ack = 1'b0;
    chk("t7_shut_alarm", alarm, 2);
    chk("t7_shut_gas", gas_code, 1);
    ack = 1'b1; step(1); ack = 1'b0;
    purge_to_run("t7", 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
